// File: rtl/soc_pmem_loader_if.sv
// Bus bundle for the program-memory loader: control, byte stream, RAM port and status.
interface soc_pmem_loader_if #(
  parameter int ADDR_MSB = 11
);
  logic                start;
  logic                abort;
  logic [ADDR_MSB:0]   base_addr;
  logic [ADDR_MSB:0]   word_cnt;
  logic [7:0]          s_data;
  logic                s_valid;
  logic                s_ready;
  logic                ram_en;
  logic [1:0]          ram_we;
  logic [ADDR_MSB:0]   ram_addr;
  logic [15:0]         ram_din;
  logic [15:0]         ram_dout;
  logic                busy;
  logic                done;
  logic                err;
  logic [15:0]         checksum;

  modport slave (
    input  start, abort, base_addr, word_cnt, s_data, s_valid, ram_dout,
    output s_ready, ram_en, ram_we, ram_addr, ram_din, busy, done, err, checksum
  );

  modport master (
    output start, abort, base_addr, word_cnt, s_data, s_valid, ram_dout,
    input  s_ready, ram_en, ram_we, ram_addr, ram_din, busy, done, err, checksum
  );
endinterface

// File: rtl/soc_pmem_loader.sv
// Loads a little-endian byte stream into program memory as 16-bit words,
// verifying each write by readback and keeping a running checksum.
module soc_pmem_loader #(
  parameter int ADDR_MSB = 11
) (
  input logic              mclk,
  input logic              reset_n,
  soc_pmem_loader_if.slave bus
);
  localparam int AW = ADDR_MSB + 1;

  typedef enum logic [2:0] {IDLE, RX_LO, RX_HI, WRITE, READ, CHECK} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [15:0]     word_q, word_d;
  logic [15:0]     csum_q, csum_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [AW-1:0]   radr_q, radr_d;
  logic [15:0]     rdin_q, rdin_d;
  logic            s_ready, ram_en;
  logic [1:0]      ram_we;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      radr_q  <= '0;
      rdin_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
      done_q  <= done_d;
      radr_q  <= radr_d;
      rdin_q  <= rdin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    err_d   = err_q;
    done_d  = 1'b0;
    radr_d  = radr_q;
    rdin_d  = rdin_q;
    s_ready = 1'b0;
    ram_en  = 1'b0;
    ram_we  = 2'b00;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          err_d  = 1'b0;
          csum_d = '0;
          if (bus.word_cnt != '0) begin
            addr_d  = bus.base_addr;
            cnt_d   = bus.word_cnt;
            state_d = RX_LO;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RX_LO: begin
        // abort withdraws ready so no byte is consumed on the cancel cycle
        s_ready = !bus.abort;
        if (bus.s_valid && !bus.abort) begin
          word_d[7:0] = bus.s_data;
          state_d     = RX_HI;
        end
      end
      RX_HI: begin
        s_ready = !bus.abort;
        if (bus.s_valid && !bus.abort) begin
          word_d[15:8] = bus.s_data;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        ram_en  = 1'b1;
        ram_we  = 2'b11;
        radr_d  = addr_q;
        rdin_d  = word_q;
        csum_d  = csum_q + word_q;
        state_d = READ;
      end
      READ: begin
        ram_en  = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        if (!bus.abort) begin
          if (bus.ram_dout != word_q) err_d = 1'b1;
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RX_LO;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  // RAM address/data follow the live values in WRITE and hold them afterwards
  assign bus.ram_addr = (state_q == WRITE) ? addr_q : radr_q;
  assign bus.ram_din  = (state_q == WRITE) ? word_q : rdin_q;
  assign bus.ram_en   = ram_en;
  assign bus.ram_we   = ram_we;
  assign bus.s_ready  = s_ready;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.checksum = csum_q;
endmodule

// File: tb/tb_soc_pmem_loader.sv
// Directed bench for soc_pmem_loader with a synchronous RAM model and readback fault injection.
module tb_soc_pmem_loader;
  logic mclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 mclk = ~mclk;

  soc_pmem_loader_if #(.ADDR_MSB(11)) bus();
  soc_pmem_loader #(.ADDR_MSB(11)) dut (.mclk(mclk), .reset_n(reset_n), .bus(bus));

  logic [15:0] mem [0:4095];
  int total = 0, bad = 0;
  int cyc = 0, rd_num = 0, inj_at = -1;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, rdy_bad = 0;
  int first_cyc = 0;
  logic busy_seen = 1'b0, track_first = 1'b0;
  logic [11:0] last_wa = '0;

  always @(posedge mclk) cyc <= cyc + 1;

  // RAM: read data appears the cycle after an enabled read; inj_at flips bit 0 of one read
  always @(posedge mclk) begin
    if (bus.ram_en) begin
      if (bus.ram_we[0]) mem[bus.ram_addr][7:0]  <= bus.ram_din[7:0];
      if (bus.ram_we[1]) mem[bus.ram_addr][15:8] <= bus.ram_din[15:8];
      if (bus.ram_we == 2'b00) begin
        bus.ram_dout <= mem[bus.ram_addr] ^ ((rd_num == inj_at) ? 16'h0001 : 16'h0000);
        rd_num <= rd_num + 1;
      end
    end
  end

  always @(negedge mclk) begin
    if (reset_n) begin
      if (bus.ram_en && bus.ram_we == 2'b11) begin wr_cnt <= wr_cnt + 1; last_wa <= bus.ram_addr; end
      if (bus.ram_en && bus.ram_we == 2'b00) rd_cnt <= rd_cnt + 1;
      if (bus.done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (bus.busy) busy_seen <= 1'b1;
      if (bus.s_ready && (!bus.busy || bus.ram_en)) rdy_bad <= rdy_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start_load(input logic [11:0] b, input logic [11:0] n);
    bus.base_addr = b; bus.word_cnt = n; bus.start = 1'b1;
    @(posedge mclk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit rnd);
    bit hs = 0;
    int g = 0;
    if (rnd) while ($urandom_range(1, 0) == 1) begin bus.s_valid = 1'b0; @(posedge mclk); #1; end
    bus.s_data = d; bus.s_valid = 1'b1;
    do begin
      @(negedge mclk);
      hs = bus.s_ready;
      if (hs && track_first) begin first_cyc = cyc; track_first = 1'b0; end
      @(posedge mclk); #1;
      g++;
    end while (!hs && g < 50);
    if (!hs) chk("byte_accept_timeout", 0, 1);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit rnd);
    send_byte(w[7:0], rnd);
    send_byte(w[15:8], rnd);
  endtask

  task automatic wait_done(input int n0, input string tag);
    int g = 0;
    while (done_cnt == n0 && g < 100) begin @(posedge mclk); #1; g++; end
    chk(tag, done_cnt != n0, 1);
  endtask

  initial begin
    int d0, w0;
    logic [15:0] rw [4];
    rw = '{16'hBEEF, 16'h0102, 16'hA5A5, 16'h7F80};
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    bus.start = 1'b1; bus.abort = 1'b0; bus.base_addr = 12'h123; bus.word_cnt = 12'h005;
    bus.s_data = 8'hFF; bus.s_valid = 1'b1; bus.ram_dout = '0;
    #23;
    chk("rst_ctrl", {bus.s_ready, bus.ram_en, bus.busy, bus.done, bus.err}, 0);
    chk("rst_we", bus.ram_we, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_din", bus.ram_din, 0);
    chk("rst_csum", bus.checksum, 0);
    bus.start = 1'b0; bus.s_valid = 1'b0;
    @(posedge mclk); #1; reset_n = 1'b1;
    @(posedge mclk); #1;

    // basic two-word load with latency check
    d0 = done_cnt; w0 = wr_cnt; track_first = 1'b1;
    start_load(12'h010, 12'd2);
    send_word(16'h1234, 0);
    send_word(16'h5678, 0);
    wait_done(d0, "t1_done");
    chk("t1_mem0", mem[12'h010], 16'h1234);
    chk("t1_mem1", mem[12'h011], 16'h5678);
    chk("t1_csum", bus.checksum, 16'h68AC);
    chk("t1_err", bus.err, 0);
    chk("t1_writes", wr_cnt - w0, 2);
    chk("t1_latency", done_cyc - first_cyc, 10);
    repeat (3) begin @(posedge mclk); #1; end
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_busy", bus.busy, 0);

    // address wrap
    d0 = done_cnt;
    start_load(12'hFFF, 12'd2);
    send_word(16'h0001, 0);
    send_word(16'h0002, 0);
    wait_done(d0, "t2_done");
    chk("t2_mem_fff", mem[12'hFFF], 16'h0001);
    chk("t2_mem_000", mem[12'h000], 16'h0002);
    chk("t2_last_addr", last_wa, 12'h000);
    chk("t2_csum", bus.checksum, 16'h0003);

    // readback mismatch on first word
    d0 = done_cnt; inj_at = rd_num;
    start_load(12'h100, 12'd2);
    send_word(16'h55AA, 0);
    send_byte(8'hCC, 0);
    chk("t3_err_after_w1", bus.err, 1);
    send_byte(8'h33, 0);
    wait_done(d0, "t3_done");
    chk("t3_mem1", mem[12'h101], 16'h33CC);
    repeat (5) begin @(posedge mclk); #1; end
    chk("t3_err_sticky", bus.err, 1);
    inj_at = -1;

    // zero-length start: done next cycle, err/checksum cleared, no RAM activity
    @(negedge mclk); busy_seen = 1'b0; @(posedge mclk); #1;
    d0 = done_cnt; w0 = wr_cnt + rd_cnt;
    start_load(12'h050, 12'd0);
    chk("t4_done_pulse", bus.done, 1);
    chk("t4_err_clr", bus.err, 0);
    chk("t4_csum_clr", bus.checksum, 0);
    @(posedge mclk); #1;
    chk("t4_done_low", bus.done, 0);
    repeat (3) begin @(posedge mclk); #1; end
    chk("t4_no_ram", (wr_cnt + rd_cnt) - w0, 0);
    chk("t4_busy_never", busy_seen, 0);

    // abort in RX_HI of word 3 of 5
    d0 = done_cnt; w0 = wr_cnt;
    start_load(12'h200, 12'd5);
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    send_byte(8'h33, 0);
    bus.abort = 1'b1;
    @(posedge mclk); #1;
    bus.abort = 1'b0;
    chk("t5_idle", bus.busy, 0);
    repeat (20) begin @(posedge mclk); #1; end
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_writes", wr_cnt - w0, 2);
    chk("t5_csum_kept", bus.checksum, 16'h3333);
    chk("t5_mem2_untouched", mem[12'h202], 16'h0000);

    // random s_valid gaps
    d0 = done_cnt;
    start_load(12'h300, 12'd4);
    for (int i = 0; i < 4; i++) send_word(rw[i], 1);
    wait_done(d0, "t6_done");
    for (int i = 0; i < 4; i++) chk($sformatf("t6_mem%0d", i), mem[12'h300 + i], rw[i]);
    chk("t6_csum", bus.checksum, 16'hE516);
    chk("t6_ready_outside_rx", rdy_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/soc_pmem_loader.md
SOC_PMEM_LOADER -- requirements
Module: soc_pmem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_MSB, default 11, giving the MSB of the program-memory word address.
REQ-002 The block SHALL have port mclk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, a load request sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1, a synchronous cancel of a load in progress.
REQ-006 The block SHALL have port base_addr, input, ADDR_MSB+1, the first word address, captured on start.
REQ-007 The block SHALL have port word_cnt, input, ADDR_MSB+1, the number of 16-bit words to load, captured on start.
REQ-008 The block SHALL have port s_data, input, 8, the byte stream, low byte of each word first.
REQ-009 The block SHALL have port s_valid, input, 1, qualifying s_data.
REQ-010 The block SHALL have port s_ready, output, 1; a byte transfers when s_valid and s_ready are both high.
REQ-011 The block SHALL have port ram_en, output, 1, the RAM port enable (active-high).
REQ-012 The block SHALL have port ram_we, output, 2, per-byte write enables (active-high).
REQ-013 The block SHALL have port ram_addr, output, ADDR_MSB+1, the RAM word address.
REQ-014 The block SHALL have port ram_din, output, 16, the RAM write data.
REQ-015 The block SHALL have port ram_dout, input, 16, the RAM read data, valid the cycle after an enabled read.
REQ-016 The block SHALL have port busy, output, 1, high whenever the block is not in IDLE.
REQ-017 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-018 The block SHALL have port err, output, 1, a sticky readback-mismatch flag.
REQ-019 The block SHALL have port checksum, output, 16, the running sum of written words.

Function
REQ-020 The FSM SHALL have states IDLE, RX_LO, RX_HI, WRITE, READ, CHECK.
REQ-021 In IDLE with start=1 and word_cnt!=0, the block SHALL capture base_addr and word_cnt, clear err and checksum, and go to RX_LO next cycle.
REQ-022 In IDLE with start=1 and word_cnt=0, the block SHALL clear err and checksum, stay in IDLE, and pulse done the next cycle.
REQ-023 s_ready SHALL be high only in RX_LO and RX_HI; on a transfer, RX_LO stores data[7:0] and goes to RX_HI, and RX_HI stores data[15:8] and goes to WRITE.
REQ-024 In WRITE the block SHALL drive ram_en=1, ram_we=2'b11, ram_addr=current address, ram_din=assembled word, add the word to checksum (mod 2^16), then go to READ.
REQ-025 In READ the block SHALL drive ram_en=1, ram_we=2'b00, ram_addr=the same address, then go to CHECK.
REQ-026 In CHECK, ram_en SHALL be 0; if ram_dout differs from the assembled word, err SHALL be set.
REQ-027 In CHECK, the address SHALL increment modulo 2^(ADDR_MSB+1) (wrapping from all-ones to 0) and the remaining count SHALL decrement.
REQ-028 From CHECK, if the remaining count was 1, the block SHALL go to IDLE with done=1 for exactly that next cycle; otherwise it SHALL go to RX_LO.
REQ-029 Outside WRITE and READ, ram_en SHALL be 0 and ram_we SHALL be 2'b00, with ram_addr and ram_din holding their last values.
REQ-030 Per-word latency SHALL be 5 cycles with s_valid held high: RX_LO, RX_HI, WRITE, READ, CHECK.
REQ-031 start SHALL be ignored when not in IDLE.
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE next cycle with no done pulse, and err and checksum retained.
REQ-033 abort SHALL take priority over a handshake or RAM access in the same cycle; a RAM access already driven that cycle still occurs.
REQ-034 A mismatch SHALL NOT stop the load; err SHALL stay set until the next accepted start or reset.

Reset
REQ-035 While reset_n=0, the block SHALL hold state IDLE, with s_ready, ram_en, busy, done and err at 0, and ram_we, ram_addr, ram_din and checksum all at 0.
REQ-036 Reset asserted mid-load SHALL take effect immediately; no further RAM access occurs and no done pulse is produced after release.

Verification
REQ-037 The bench SHALL check: base_addr=0x010, word_cnt=2, bytes 34 12 78 56 with an ideal RAM model -> writes 0x1234@0x010 and 0x5678@0x011, checksum=0x68AC, done pulses once, err=0, 10 cycles from first byte accepted to done.
REQ-038 The bench SHALL check: base_addr=0xFFF, word_cnt=2 -> the second write goes to address 0x000 (wrap).
REQ-039 The bench SHALL check: the RAM model forces bit 0 of the read data for the first word -> err=1 after the first CHECK, the second word is still written, done pulses, and err holds until the next start.
REQ-040 The bench SHALL check: start with word_cnt=0 -> done pulses the next cycle with no RAM access, and busy is never high.
REQ-041 The bench SHALL check: abort asserted in RX_HI of word 3 of 5 -> IDLE next cycle, no done, and only 2 words written.
REQ-042 The bench SHALL check: s_valid toggling randomly -> identical RAM contents, and s_ready is never high outside RX states.
